ldpc_3gpp_enc_reg_ctrl: RTL and testbench
=========================================

Name: ldpc_3gpp_enc_reg_ctrl

Overview:
Sequencer and arbiter for the encoder's single-port matrix register.
- Shares the register between one writer (source-word loader) and one reader (matrix-multiply unit).
- Generates its write, write-start, read and read-start strobes as bursts of len words, where len = Zc/pDAT_W.
- Tracks a single-buffer full/empty flag so a read never returns stale data and a write never overwrites unread data.

Parameters:
pADDR_W, 8, register address width; a burst holds at most 2**pADDR_W words.
pGAP, 1, idle cycles inserted between any two bursts (0..3).

Ports:
iclk  in  1  clock
ireset_n  in  1  asynchronous active-low reset
iclkena  in  1  clock enable; when low, all state, counters and outputs hold
ilen_m1  in  pADDR_W  burst length minus 1 (Zc/pDAT_W - 1); sampled at burst start
iwreq  in  1  writer request; level, held until owgnt
owgnt  out  1  one-cycle pulse: write burst granted, starts next cycle
owrdy  out  1  writer must present a data word this cycle; high for exactly len cycles
iwabort  in  1  writer abort; ends the write burst early, buffer stays empty
irreq  in  1  reader request; level, held until orgnt
irrel  in  1  release flag, sampled with orgnt; 1 = buffer becomes empty after this read
orgnt  out  1  one-cycle pulse: read burst granted
ofull  out  1  buffer holds valid unread data
obusy  out  1  FSM not in IDLE
oreg_write  out  1  to register write strobe
oreg_wstart  out  1  to register write-start (first word)
oreg_read  out  1  to register read strobe
oreg_rstart  out  1  to register read-start (first word)
owdone  out  1  one-cycle pulse after last write word
ordone  out  1  one-cycle pulse after last read word

Behaviour:
Reset and clock enable:
- Reset (async assert, sync release): state IDLE, full=0, counters 0.
- Every output resets to 0.
- Everything below applies only on iclkena=1.

FSM states: IDLE, WBURST, RBURST, GAP.

IDLE:
- If full=0 and iwreq=1: owgnt=1, latch len=ilen_m1, go to WBURST.
- Else if full=1 and irreq=1: orgnt=1, latch len and irrel, go to RBURST.
- iwreq while full and irreq while empty wait; they are never granted and never lost.
- Simultaneous iwreq and irreq cannot collide: the full flag selects exactly one.

WBURST:
- owrdy=oreg_write=1 for len_m1+1 cycles; oreg_wstart=1 on the first cycle only.
- Word counter runs 0..len_m1; on the last word: owdone=1 next cycle, full<=1, go to GAP.
- iwabort=1: drop oreg_write immediately, leave full=0, no owdone, go to GAP.

RBURST:
- oreg_read=1 for len_m1+1 cycles; oreg_rstart=1 on the first cycle only.
- On the last word: ordone=1 next cycle, full<=~rel_latched, go to GAP.

GAP:
- Waits pGAP cycles (counter), then returns to IDLE.
- pGAP=0 goes straight to IDLE on the same edge. No grant is issued in GAP.

Strobes and timing:
- All strobes are registered.
- Latency from owgnt/orgnt pulse to the first strobe is 1 cycle.
- Strobes for the same burst are contiguous.
- Read data appears at the register output 3/4 cycles after oreg_read (register pPIPE); this block does not wait for it.

Boundary conditions:
- ilen_m1=0: single-word burst with start and strobe in the same cycle.
- ilen_m1=2**pADDR_W-1: full-depth burst; the counter must not wrap early.
- ilen_m1 changing mid-burst is ignored.
- oreg_write and oreg_read are never high together (assertion).
- Reset mid-burst: strobes drop asynchronously and full is cleared.

Decomposition:
- Package ldpc_3gpp_enc_reg_ctrl_pkg holds the state enum (IDLE/WBURST/RBURST/GAP) and the len_t typedef, logic[pADDR_W-1:0] carried as a parameterised width.
- One natural sub-module: ldpc_3gpp_enc_reg_burst_cnt, a loadable down-counter with last flag, instantiated once and shared by both bursts, since they are mutually exclusive.

Test Plan:
1. Reset, then ilen_m1=3 with iwreq=1: owgnt at cycle 1; oreg_write high cycles 2..5 with oreg_wstart at cycle 2; owdone at cycle 6; ofull=1.
2. After 1, irreq=1 with irrel=1: orgnt, then oreg_read for 4 cycles with oreg_rstart on the first; ordone follows; ofull=0. End-to-end with the spram, odat returns the 4 written words in order.
3. Full=1 with iwreq and irreq both high: read is granted first and iwreq waits. With irrel=0, ofull stays 1 and the write is never granted until a releasing read occurs.
4. ilen_m1=0 and ilen_m1=255 (pADDR_W=8): exactly 1 and 256 strobes; single-cycle start/strobe in the first case.
5. iwabort on the 2nd write word: oreg_write stops, no owdone, ofull=0, and a next iwreq is granted after pGAP cycles.
6. iclkena toggled low mid-burst: strobe count is unchanged but stretched. ireset_n pulsed mid-read: all outputs 0 immediately and ofull=0.

Source files
------------

// File: rtl/ldpc_3gpp_enc_reg_ctrl_pkg.sv
// Shared types for the matrix-register sequencer: FSM states and the burst length type.
package ldpc_3gpp_enc_reg_ctrl_pkg;

  typedef enum logic [1:0] {IDLE, WBURST, RBURST, GAP} state_t;

  localparam int cADDR_W = 8;
  typedef logic [cADDR_W-1:0] len_t;

  function automatic logic in_burst(input state_t s);
    return (s == WBURST) || (s == RBURST);
  endfunction

endpackage

// File: rtl/ldpc_3gpp_enc_reg_burst_cnt.sv
// Loadable down-counter shared by write and read bursts; last is high when the count is zero.
module ldpc_3gpp_enc_reg_burst_cnt #(
  parameter int pADDR_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ena,
  input  logic               load,
  input  logic [pADDR_W-1:0] load_val,
  input  logic               dec,
  output logic               last
);

  logic [pADDR_W-1:0] cnt;

  // Saturates at zero so the tail cycle of a burst cannot wrap the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (ena) begin
      if (load) begin
        cnt <= load_val;
      end else if (dec && (cnt != '0)) begin
        cnt <= cnt - pADDR_W'(1);
      end
    end
  end

  assign last = (cnt == '0);

endmodule

// File: rtl/ldpc_3gpp_enc_reg_ctrl.sv
// Arbiter/sequencer for the encoder's single-port matrix register: one writer, one reader,
// single-buffer full flag, registered burst strobes.
module ldpc_3gpp_enc_reg_ctrl
  import ldpc_3gpp_enc_reg_ctrl_pkg::*;
#(
  parameter int pADDR_W = cADDR_W,
  parameter int pGAP    = 1
) (
  input  logic               iclk,
  input  logic               ireset_n,
  input  logic               iclkena,
  input  logic [pADDR_W-1:0] ilen_m1,
  input  logic               iwreq,
  output logic               owgnt,
  output logic               owrdy,
  input  logic               iwabort,
  input  logic               irreq,
  input  logic               irrel,
  output logic               orgnt,
  output logic               ofull,
  output logic               obusy,
  output logic               oreg_write,
  output logic               oreg_wstart,
  output logic               oreg_read,
  output logic               oreg_rstart,
  output logic               owdone,
  output logic               ordone
);

  localparam logic [1:0] GAP_M1 = (pGAP > 0) ? 2'(pGAP - 1) : 2'd0;
  localparam state_t     POST   = (pGAP > 0) ? GAP : IDLE;

  state_t     state;
  logic       full;
  logic       rel;
  logic       first;
  logic       tail;
  logic [1:0] gap_cnt;

  logic grant_w;
  logic grant_r;
  logic cnt_load;
  logic cnt_dec;
  logic cnt_last;

  // The full flag alone decides which side may be granted, so the two never collide.
  assign grant_w  = (state == IDLE) && !full && iwreq;
  assign grant_r  = (state == IDLE) && full && irreq;
  assign cnt_load = grant_w || grant_r;
  assign cnt_dec  = in_burst(state) && !tail && !((state == WBURST) && iwabort);

  ldpc_3gpp_enc_reg_burst_cnt #(
    .pADDR_W (pADDR_W)
  ) u_cnt (
    .clk      (iclk),
    .rst_n    (ireset_n),
    .ena      (iclkena),
    .load     (cnt_load),
    .load_val (ilen_m1),
    .dec      (cnt_dec),
    .last     (cnt_last)
  );

  // Strobe cycles run while tail is low; the extra tail cycle issues the done pulse.
  always_ff @(posedge iclk or negedge ireset_n) begin
    if (!ireset_n) begin
      state       <= IDLE;
      full        <= 1'b0;
      rel         <= 1'b0;
      first       <= 1'b0;
      tail        <= 1'b0;
      gap_cnt     <= 2'd0;
      owgnt       <= 1'b0;
      orgnt       <= 1'b0;
      owrdy       <= 1'b0;
      oreg_write  <= 1'b0;
      oreg_wstart <= 1'b0;
      oreg_read   <= 1'b0;
      oreg_rstart <= 1'b0;
      owdone      <= 1'b0;
      ordone      <= 1'b0;
    end else if (iclkena) begin
      owgnt       <= 1'b0;
      orgnt       <= 1'b0;
      owrdy       <= 1'b0;
      oreg_write  <= 1'b0;
      oreg_wstart <= 1'b0;
      oreg_read   <= 1'b0;
      oreg_rstart <= 1'b0;
      owdone      <= 1'b0;
      ordone      <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_w) begin
            owgnt <= 1'b1;
            first <= 1'b1;
            tail  <= 1'b0;
            state <= WBURST;
          end else if (grant_r) begin
            orgnt <= 1'b1;
            rel   <= irrel;
            first <= 1'b1;
            tail  <= 1'b0;
            state <= RBURST;
          end
        end
        WBURST: begin
          if (iwabort) begin
            gap_cnt <= 2'd0;
            state   <= POST;
          end else if (!tail) begin
            oreg_write  <= 1'b1;
            owrdy       <= 1'b1;
            oreg_wstart <= first;
            first       <= 1'b0;
            tail        <= cnt_last;
          end else begin
            owdone  <= 1'b1;
            full    <= 1'b1;
            gap_cnt <= 2'd0;
            state   <= POST;
          end
        end
        RBURST: begin
          if (!tail) begin
            oreg_read   <= 1'b1;
            oreg_rstart <= first;
            first       <= 1'b0;
            tail        <= cnt_last;
          end else begin
            ordone  <= 1'b1;
            full    <= ~rel;
            gap_cnt <= 2'd0;
            state   <= POST;
          end
        end
        GAP: begin
          if (gap_cnt == GAP_M1) begin
            state <= IDLE;
          end else begin
            gap_cnt <= gap_cnt + 2'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign ofull = full;
  assign obusy = (state != IDLE);

  a_rw_excl: assert property (@(posedge iclk) disable iff (!ireset_n) !(oreg_write && oreg_read));

endmodule

// File: tb/tb_ldpc_3gpp_enc_reg_ctrl.sv
// Self-checking bench for ldpc_3gpp_enc_reg_ctrl: directed scenarios plus randomized
// request traffic checked against a transaction-level full/empty model.
module tb_ldpc_3gpp_enc_reg_ctrl;

  localparam int AW   = 8;
  localparam int GAPC = 1;

  logic          iclk     = 1'b0;
  logic          ireset_n = 1'b0;
  logic          iclkena  = 1'b1;
  logic [AW-1:0] ilen_m1  = '0;
  logic          iwreq    = 1'b0;
  logic          iwabort  = 1'b0;
  logic          irreq    = 1'b0;
  logic          irrel    = 1'b0;
  logic owgnt, owrdy, orgnt, ofull, obusy;
  logic oreg_write, oreg_wstart, oreg_read, oreg_rstart, owdone, ordone;
  logic [10:0] outs;

  ldpc_3gpp_enc_reg_ctrl #(.pADDR_W(AW), .pGAP(GAPC)) dut (
    .iclk(iclk), .ireset_n(ireset_n), .iclkena(iclkena), .ilen_m1(ilen_m1),
    .iwreq(iwreq), .owgnt(owgnt), .owrdy(owrdy), .iwabort(iwabort),
    .irreq(irreq), .irrel(irrel), .orgnt(orgnt), .ofull(ofull), .obusy(obusy),
    .oreg_write(oreg_write), .oreg_wstart(oreg_wstart), .oreg_read(oreg_read),
    .oreg_rstart(oreg_rstart), .owdone(owdone), .ordone(ordone)
  );

  assign outs = {owgnt, owrdy, orgnt, ofull, obusy, oreg_write, oreg_wstart,
                 oreg_read, oreg_rstart, owdone, ordone};

  always #5 iclk = ~iclk;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int n_wg = 0, n_rg = 0, n_wr = 0, n_rd = 0, n_ws = 0, n_rs = 0;
  int n_wd = 0, n_rdn = 0, n_bad = 0;
  int gw_cyc = 0, gr_cyc = 0;
  bit wfirst = 1'b0, rfirst = 1'b0;
  bit model_full = 1'b0;

  int  bnd_len [5] = '{0, 0, 255, 255, 0};
  int  bnd_w   [5] = '{0, 1, 0, 1, 0};

  always @(posedge iclk) cyc <= cyc + 1;

  // Event monitor: a pulse/strobe counts once, at the edge where the DUT is enabled.
  always @(negedge iclk) begin
    if (ireset_n) begin
      if (owrdy !== oreg_write) n_bad++;
      if (oreg_write && oreg_read) n_bad++;
      if ((oreg_wstart && !oreg_write) || (oreg_rstart && !oreg_read)) n_bad++;
      if (iclkena) begin
        if (owgnt) begin n_wg++; gw_cyc = cyc; wfirst = 1'b1; end
        if (orgnt) begin n_rg++; gr_cyc = cyc; rfirst = 1'b1; end
        if (oreg_write) begin
          n_wr++;
          if (oreg_wstart) n_ws++;
          if (oreg_wstart != wfirst) n_bad++;
          wfirst = 1'b0;
        end
        if (oreg_read) begin
          n_rd++;
          if (oreg_rstart) n_rs++;
          if (oreg_rstart != rfirst) n_bad++;
          rfirst = 1'b0;
        end
        if (owdone) n_wd++;
        if (ordone) n_rdn++;
      end
    end
  end

  task automatic step();
    @(posedge iclk);
    #1;
  endtask

  task automatic wait_idle(output bit to);
    to = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      if (!(obusy || owgnt || orgnt || owdone || ordone)) begin
        to = 1'b0;
        break;
      end
      step();
    end
  endtask

  // Drives one request pattern, drops requests at the first grant, then waits for idle.
  task automatic transact(input int w, input int r, input int rel, input int len_m1,
                          input int ena_rand, input int gnt_budget, output bit to);
    bit got;
    got = 1'b0;
    to  = 1'b1;
    ilen_m1 = AW'(len_m1);
    iwreq = (w != 0);
    irreq = (r != 0);
    irrel = (rel != 0);
    for (int c = 0; c < gnt_budget && !got; c++) begin
      iclkena = (ena_rand != 0) ? ($urandom_range(0, 3) != 0) : 1'b1;
      step();
      if (owgnt || orgnt) got = 1'b1;
    end
    iwreq = 1'b0;
    irreq = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      if (!(obusy || owgnt || orgnt || owdone || ordone)) begin
        to = 1'b0;
        break;
      end
      iclkena = (ena_rand != 0) ? ($urandom_range(0, 3) != 0) : 1'b1;
      step();
    end
    iclkena = 1'b1;
  endtask

  task automatic test_reset();
    ireset_n = 1'b0;
    step();
    step();
    n_chk++;
    if (outs !== 11'd0) begin
      n_fail++;
      $display("FAIL reset_hold outs=%b expected=%b", outs, 11'd0);
    end
    ireset_n = 1'b1;
    step();
    n_chk++;
    if (outs !== 11'd0) begin
      n_fail++;
      $display("FAIL reset_idle outs=%b expected=%b", outs, 11'd0);
    end
    model_full = 1'b0;
  endtask

  task automatic test_basic_write();
    int  len;
    bit  eg, ew, es, ed;
    bit  to;
    len = 4;
    ilen_m1 = AW'(len - 1);
    iwreq = 1'b1;
    for (int c = 1; c <= len + 3; c++) begin
      step();
      eg = (c == 1);
      ew = (c >= 2) && (c <= len + 1);
      es = (c == 2);
      ed = (c == len + 2);
      n_chk++;
      if ({owgnt, oreg_write, owrdy, oreg_wstart, owdone, oreg_read} !== {eg, ew, ew, es, ed, 1'b0}) begin
        n_fail++;
        $display("FAIL basic_wr c=%0d gnt/wr/rdy/ws/done/rd got=%b expected=%b", c,
                 {owgnt, oreg_write, owrdy, oreg_wstart, owdone, oreg_read},
                 {eg, ew, ew, es, ed, 1'b0});
      end
      if (c == 1) iwreq = 1'b0;
      if (c == 3) ilen_m1 = AW'(200);
    end
    n_chk++;
    if (ofull !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_wr_full ofull=%b expected=1", ofull);
    end
    wait_idle(to);
    n_chk++;
    if (to) begin
      n_fail++;
      $display("FAIL basic_wr_idle timeout=1 expected=0");
    end
    model_full = 1'b1;
  endtask

  task automatic test_basic_read();
    int len;
    bit eg, er, es, ed;
    bit to;
    len = 4;
    ilen_m1 = AW'(len - 1);
    irreq = 1'b1;
    irrel = 1'b1;
    for (int c = 1; c <= len + 3; c++) begin
      step();
      eg = (c == 1);
      er = (c >= 2) && (c <= len + 1);
      es = (c == 2);
      ed = (c == len + 2);
      n_chk++;
      if ({orgnt, oreg_read, oreg_rstart, ordone, oreg_write} !== {eg, er, es, ed, 1'b0}) begin
        n_fail++;
        $display("FAIL basic_rd c=%0d gnt/rd/rs/done/wr got=%b expected=%b", c,
                 {orgnt, oreg_read, oreg_rstart, ordone, oreg_write}, {eg, er, es, ed, 1'b0});
      end
      if (c == 1) irreq = 1'b0;
    end
    n_chk++;
    if (ofull !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_rd_full ofull=%b expected=0", ofull);
    end
    wait_idle(to);
    model_full = 1'b0;
  endtask

  task automatic test_priority();
    int rg0, wg0, rd0, wr0;
    bit to, got;
    transact(1, 0, 0, 2, 0, 12, to);
    model_full = 1'b1;
    n_chk++;
    if (ofull !== model_full || to) begin
      n_fail++;
      $display("FAIL prio_fill ofull=%b timeout=%b expected ofull=%b timeout=0", ofull, to, model_full);
    end
    rg0 = n_rg; wg0 = n_wg; rd0 = n_rd;
    ilen_m1 = AW'(2);
    iwreq = 1'b1; irreq = 1'b1; irrel = 1'b0;
    got = 1'b0;
    for (int c = 0; c < 12 && !got; c++) begin
      step();
      if (orgnt) got = 1'b1;
    end
    irreq = 1'b0;
    repeat (30) step();
    n_chk++;
    if ((n_rg - rg0) != 1 || (n_wg - wg0) != 0) begin
      n_fail++;
      $display("FAIL prio_hold rgnt=%0d wgnt=%0d expected rgnt=1 wgnt=0", n_rg - rg0, n_wg - wg0);
    end
    n_chk++;
    if ((n_rd - rd0) != 3) begin
      n_fail++;
      $display("FAIL prio_hold_reads reads=%0d expected=3", n_rd - rd0);
    end
    n_chk++;
    if (ofull !== 1'b1) begin
      n_fail++;
      $display("FAIL prio_hold_full ofull=%b expected=1", ofull);
    end
    rg0 = n_rg; wg0 = n_wg; wr0 = n_wr;
    irreq = 1'b1; irrel = 1'b1;
    got = 1'b0;
    for (int c = 0; c < 12 && !got; c++) begin
      step();
      if (orgnt) got = 1'b1;
    end
    irreq = 1'b0;
    got = 1'b0;
    for (int c = 0; c < 40 && !got; c++) begin
      step();
      if (owgnt) got = 1'b1;
    end
    iwreq = 1'b0;
    wait_idle(to);
    n_chk++;
    if ((n_rg - rg0) != 1 || (n_wg - wg0) != 1 || to) begin
      n_fail++;
      $display("FAIL prio_release rgnt=%0d wgnt=%0d timeout=%b expected 1 1 0", n_rg - rg0, n_wg - wg0, to);
    end
    n_chk++;
    if (!(gr_cyc < gw_cyc)) begin
      n_fail++;
      $display("FAIL prio_order read_cyc=%0d write_cyc=%0d expected read before write", gr_cyc, gw_cyc);
    end
    n_chk++;
    if ((n_wr - wr0) != 3 || ofull !== 1'b1) begin
      n_fail++;
      $display("FAIL prio_refill writes=%0d ofull=%b expected writes=3 ofull=1", n_wr - wr0, ofull);
    end
    model_full = 1'b1;
  endtask

  task automatic test_boundary();
    int wr0, rd0, ws0, rs0, exp_w, exp_r;
    bit to;
    for (int i = 0; i < 5; i++) begin
      wr0 = n_wr; rd0 = n_rd; ws0 = n_ws; rs0 = n_rs;
      transact(bnd_w[i], 1 - bnd_w[i], 1, bnd_len[i], 0, 12, to);
      exp_w = (bnd_w[i] != 0) ? bnd_len[i] + 1 : 0;
      exp_r = (bnd_w[i] != 0) ? 0 : bnd_len[i] + 1;
      model_full = (bnd_w[i] != 0);
      n_chk++;
      if ((n_wr - wr0) != exp_w || (n_rd - rd0) != exp_r || to) begin
        n_fail++;
        $display("FAIL bound_len%0d writes=%0d reads=%0d timeout=%b expected writes=%0d reads=%0d",
                 bnd_len[i], n_wr - wr0, n_rd - rd0, to, exp_w, exp_r);
      end
      n_chk++;
      if ((n_ws - ws0) + (n_rs - rs0) != 1) begin
        n_fail++;
        $display("FAIL bound_start%0d starts=%0d expected=1", i, (n_ws - ws0) + (n_rs - rs0));
      end
      n_chk++;
      if (ofull !== model_full) begin
        n_fail++;
        $display("FAIL bound_full%0d ofull=%b expected=%b", i, ofull, model_full);
      end
    end
  endtask

  task automatic test_abort();
    int wr0, wd0, seen, k;
    bit got, to;
    wr0 = n_wr; wd0 = n_wd;
    ilen_m1 = AW'(5);
    iwreq = 1'b1;
    seen = 0;
    for (int c = 0; c < 20 && seen < 2; c++) begin
      step();
      if (owgnt) iwreq = 1'b0;
      if (oreg_write) seen++;
    end
    iwabort = 1'b1;
    iwreq = 1'b1;
    step();
    iwabort = 1'b0;
    n_chk++;
    if (oreg_write !== 1'b0 || owdone !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_stop wr=%b done=%b expected 0 0", oreg_write, owdone);
    end
    k = 0;
    got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      step();
      k++;
      if (owgnt) got = 1'b1;
    end
    n_chk++;
    if (!got || k != GAPC + 1) begin
      n_fail++;
      $display("FAIL abort_regrant cycles=%0d granted=%b expected cycles=%0d", k, got, GAPC + 1);
    end
    n_chk++;
    if ((n_wr - wr0) != 2 || (n_wd - wd0) != 0 || ofull !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_state writes=%0d done=%0d ofull=%b expected 2 0 0", n_wr - wr0, n_wd - wd0, ofull);
    end
    iwreq = 1'b0;
    wait_idle(to);
    model_full = 1'b1;
    n_chk++;
    if ((n_wr - wr0) != 8 || (n_wd - wd0) != 1 || ofull !== model_full || to) begin
      n_fail++;
      $display("FAIL abort_next writes=%0d done=%0d ofull=%b timeout=%b expected 8 1 1 0",
               n_wr - wr0, n_wd - wd0, ofull, to);
    end
  endtask

  task automatic test_clkena();
    int rd0, rs0, rdn0, wr0, seen;
    bit to;
    rd0 = n_rd; rs0 = n_rs; rdn0 = n_rdn;
    transact(0, 1, 1, 7, 1, 40, to);
    model_full = 1'b0;
    n_chk++;
    if ((n_rd - rd0) != 8 || (n_rs - rs0) != 1 || (n_rdn - rdn0) != 1 || to) begin
      n_fail++;
      $display("FAIL ena_read reads=%0d starts=%0d done=%0d timeout=%b expected 8 1 1 0",
               n_rd - rd0, n_rs - rs0, n_rdn - rdn0, to);
    end
    wr0 = n_wr;
    transact(1, 0, 0, 9, 1, 40, to);
    model_full = 1'b1;
    n_chk++;
    if ((n_wr - wr0) != 10 || ofull !== model_full || to) begin
      n_fail++;
      $display("FAIL ena_write writes=%0d ofull=%b timeout=%b expected 10 1 0", n_wr - wr0, ofull, to);
    end
    ilen_m1 = AW'(20);
    irreq = 1'b1; irrel = 1'b0;
    seen = 0;
    for (int c = 0; c < 40 && seen < 5; c++) begin
      step();
      if (orgnt) irreq = 1'b0;
      if (oreg_read) seen++;
    end
    irreq = 1'b0;
    n_chk++;
    if (oreg_read !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_mid_pre rd=%b expected=1", oreg_read);
    end
    #2 ireset_n = 1'b0;
    #1;
    n_chk++;
    if (outs !== 11'd0) begin
      n_fail++;
      $display("FAIL rst_mid_async outs=%b expected=%b", outs, 11'd0);
    end
    step();
    ireset_n = 1'b1;
    step();
    model_full = 1'b0;
    n_chk++;
    if (ofull !== model_full || obusy !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_after ofull=%b busy=%b expected 0 0", ofull, obusy);
    end
  endtask

  task automatic test_random();
    int w, r, rel, len, ena, ew, er;
    int wg0, rg0, wr0, rd0, wd0, rdn0;
    bit to;
    for (int i = 0; i < 40; i++) begin
      w   = $urandom_range(0, 1);
      r   = $urandom_range(0, 1);
      rel = $urandom_range(0, 1);
      len = $urandom_range(0, 15);
      ena = $urandom_range(0, 1);
      ew  = (!model_full && w != 0) ? 1 : 0;
      er  = (model_full && r != 0) ? 1 : 0;
      wg0 = n_wg; rg0 = n_rg; wr0 = n_wr; rd0 = n_rd; wd0 = n_wd; rdn0 = n_rdn;
      transact(w, r, rel, len, ena, 14, to);
      if (ew != 0) model_full = 1'b1;
      if (er != 0) model_full = (rel == 0);
      n_chk++;
      if ((n_wg - wg0) != ew || (n_rg - rg0) != er || to) begin
        n_fail++;
        $display("FAIL rand%0d_grant wgnt=%0d rgnt=%0d timeout=%b expected wgnt=%0d rgnt=%0d",
                 i, n_wg - wg0, n_rg - rg0, to, ew, er);
      end
      n_chk++;
      if ((n_wr - wr0) != ew * (len + 1) || (n_rd - rd0) != er * (len + 1) ||
          (n_wd - wd0) != ew || (n_rdn - rdn0) != er) begin
        n_fail++;
        $display("FAIL rand%0d_strobes writes=%0d reads=%0d wdone=%0d rdone=%0d expected %0d %0d %0d %0d",
                 i, n_wr - wr0, n_rd - rd0, n_wd - wd0, n_rdn - rdn0,
                 ew * (len + 1), er * (len + 1), ew, er);
      end
      n_chk++;
      if (ofull !== model_full) begin
        n_fail++;
        $display("FAIL rand%0d_full ofull=%b expected=%b", i, ofull, model_full);
      end
    end
  endtask

  task automatic test_final();
    n_chk++;
    if (n_bad != 0) begin
      n_fail++;
      $display("FAIL strobe_rules violations=%0d expected=0", n_bad);
    end
  endtask

  initial begin
    test_reset();
    test_basic_write();
    test_basic_read();
    test_priority();
    test_boundary();
    test_abort();
    test_clkena();
    test_random();
    test_final();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
